lc3_seq_datapath: RTL and testbench
===================================

LC3_SEQ_DATAPATH -- requirements
Module: lc3_seq_datapath

Interface
REQ-001 Parameter WIDTH, default 16, is the datapath/register/address width; legal range 16..32.
REQ-002 Parameter RESET_PC, default 16'h3000 zero-extended to WIDTH, is the PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  memory request valid.
REQ-006 mem_we  output  1  1 = write, 0 = read; meaningful only while mem_req=1.
REQ-007 mem_addr  output  WIDTH  request address.
REQ-008 mem_wdata  output  WIDTH  store data.
REQ-009 mem_rdata  input  WIDTH  read data; valid in the cycle mem_ready=1.
REQ-010 mem_ready  input  1  request complete; sampled only while mem_req=1.
REQ-011 pc_out  output  WIDTH  current PC register.
REQ-012 ir_out  output  16  current IR register.
REQ-013 cc_out  output  3  condition codes {N,Z,P}.
REQ-014 halted  output  1  high while in HALT state.
REQ-015 illegal_op  output  1  one-cycle pulse when an unsupported opcode executes.

Function
REQ-016 States: FETCH, DECODE, EXEC, MEM, HALT; one-hot or encoded at implementer's choice.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready: IR<=mem_rdata[15:0], PC<=PC+1 (mod 2^WIDTH), ->DECODE; else remain.
REQ-018 DECODE: exactly one cycle; register-file reads of SR1/BaseR and SR2 occur here; ->EXEC.
REQ-019 Register file: 8 x WIDTH; R0..R7; fields per LC-3 encoding (DR/SR=IR[11:9], SR1/BaseR=IR[8:6], SR2=IR[2:0]).
REQ-020 All immediates/offsets (imm5, off6, off9) sign-extended to WIDTH; arithmetic wraps mod 2^WIDTH.
REQ-021 EXEC ADD(0001)/AND(0101): DR<=SR1 op (IR[5]? sext(imm5) : SR2); CC updated; ->FETCH.
REQ-022 EXEC NOT(1001): DR<=~SR1; CC updated; ->FETCH.
REQ-023 EXEC BR(0000): if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), PC<=PC+sext(off9); else no change; nzp=000 never branches; ->FETCH.
REQ-024 EXEC JMP(1100): PC<=BaseR; ->FETCH.
REQ-025 EXEC LEA(1110): DR<=PC+sext(off9); CC unchanged; ->FETCH.
REQ-026 EXEC LD(0010)/ST(0011): MAR<=PC+sext(off9); LDR(0110)/STR(0111): MAR<=BaseR+sext(off6); store data register<=DR-field register; ->MEM.
REQ-027 MEM: mem_req=1, mem_addr=MAR, mem_we=1 for ST/STR, mem_wdata=store data; on mem_ready: loads write DR<=mem_rdata and update CC; ->FETCH.
REQ-028 mem_addr, mem_we, mem_wdata SHALL be stable from first mem_req cycle until the cycle mem_ready=1 inclusive.
REQ-029 mem_ready asserted with mem_req=1 in the first request cycle completes the access in that cycle (zero wait states).
REQ-030 mem_ready while mem_req=0 SHALL be ignored.
REQ-031 TRAP(1111): ->HALT; HALT holds all state, mem_req=0, halted=1, until reset.
REQ-032 Any other opcode (JSR 0100, LDI 1010, STI 1011, RTI 1000, 1101): no architectural change, illegal_op=1 for the EXEC cycle, ->FETCH.
REQ-033 CC: N if result MSB (bit WIDTH-1)=1, Z if result=0, P otherwise; exactly one bit set.
REQ-034 Register writes in a cycle are visible to reads in the following cycle; no same-cycle bypass required.
REQ-035 Instruction throughput: ALU/BR/JMP/LEA = 3 cycles + fetch waits; loads/stores = 4 cycles + fetch and data waits.

Reset
REQ-036 reset=1 at a rising edge: PC<=RESET_PC, IR<=0, R0..R7<=0, CC<=3'b010, MAR<=0, state<=FETCH.
REQ-037 During and in the cycle after a reset edge outputs SHALL be: mem_req=0 while reset=1, halted=0, illegal_op=0; first fetch request in the first cycle reset=0.
REQ-038 Reset mid-access (FETCH or MEM with mem_req=1) abandons the access; no register, PC or CC update from it.

Verification
REQ-039 ADD immediate: R1=5, fetch 0x1261 (ADD R1,R1,#1), ready each request -> R1=6, CC=001, PC=0x3001 after 3 cycles.
REQ-040 Branch: CC=010, fetch 0x0405 (BRz +5) at 0x3000 -> PC=0x3006; with CC=001 -> PC=0x3001.
REQ-041 Load with waits: fetch 0x2202 (LD R1,+2) at 0x3000, mem_ready delayed 3 cycles, data 0x8000 -> mem_addr=0x3003 held stable, R1=0x8000, CC=100.
REQ-042 Store/STR: R2=0x1234, R3=0x4000, fetch 0x74FF (STR R2,R3,#-1) -> write req addr 0x3FFF, wdata 0x1234, mem_we=1.
REQ-043 TRAP 0xF025 -> halted=1, mem_req=0 indefinitely; reset -> PC=0x3000, halted=0, fetch resumes.
REQ-044 WIDTH=32: ADD R1,R1,#-1 with R1=0 -> R1=0xFFFFFFFF, CC=100; opcode 0xD000 -> illegal_op pulse one cycle, no register change.

Source files
------------

// File: rtl/lc3_seq_datapath.sv
// lc3_seq_datapath
// ----------------
// Multi-cycle sequencer and datapath for a subset of the LC-3 ISA.
// Each instruction walks FETCH -> DECODE -> EXEC, and loads and stores
// add a MEM step before returning to FETCH. TRAP parks the core in HALT
// until the next reset.
//
// Parameters
//   WIDTH     datapath, register and address width (16..32)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk         sole clock, rising-edge
//   reset       synchronous active-high reset
//   mem_req     memory request valid (FETCH and MEM states)
//   mem_we      1 = write (ST/STR), 0 = read
//   mem_addr    request address (PC in FETCH, MAR in MEM)
//   mem_wdata   store data
//   mem_rdata   read data, taken in the cycle mem_ready=1
//   mem_ready   request complete; looked at only while mem_req=1
//   pc_out      current PC
//   ir_out      current instruction register
//   cc_out      condition codes {N,Z,P}
//   halted      high while parked in HALT
//   illegal_op  one-cycle pulse in EXEC of an unsupported opcode
module lc3_seq_datapath #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(16'h3000)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic [15:0]      ir_out,
    output logic [2:0]       cc_out,
    output logic             halted,
    output logic             illegal_op
);

    // Sequencer states
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    // Supported opcodes
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Architectural and sequencing state
    logic [2:0]       state;
    logic [WIDTH-1:0] pc;
    logic [15:0]      ir;
    logic [2:0]       cc;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] regs [8];

    // Operands captured from the register file in DECODE
    logic [WIDTH-1:0] sr1_val;
    logic [WIDTH-1:0] sr2_val;

    // Instruction fields and derived values
    logic [3:0]       opcode;
    logic [2:0]       dr_sel;
    logic [2:0]       sr1_sel;
    logic [2:0]       sr2_sel;
    logic [WIDTH-1:0] imm5;
    logic [WIDTH-1:0] off6;
    logic [WIDTH-1:0] off9;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] pc_rel;
    logic [WIDTH-1:0] base_rel;
    logic             is_store;
    logic             branch_taken;
    logic             op_illegal;

    // N/Z/P classification of a result written to a register
    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return 3'b100;
        end else if (v == '0) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    always_comb begin
        opcode  = ir[15:12];
        dr_sel  = ir[11:9];
        sr1_sel = ir[8:6];
        sr2_sel = ir[2:0];

        imm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
        off6 = {{(WIDTH-6){ir[5]}}, ir[5:0]};
        off9 = {{(WIDTH-9){ir[8]}}, ir[8:0]};

        // pc already points past the instruction by the time EXEC runs
        pc_rel   = pc + off9;
        base_rel = sr1_val + off6;

        alu_b = ir[5] ? imm5 : sr2_val;
        case (opcode)
            OP_ADD:  alu_result = sr1_val + alu_b;
            OP_AND:  alu_result = sr1_val & alu_b;
            OP_NOT:  alu_result = ~sr1_val;
            default: alu_result = '0;
        endcase

        branch_taken = (ir[11] & cc[2]) | (ir[10] & cc[1]) | (ir[9] & cc[0]);
        is_store     = (opcode == OP_ST) || (opcode == OP_STR);

        case (opcode)
            OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_LDR, OP_STR,
            OP_NOT, OP_JMP, OP_LEA, OP_TRAP: op_illegal = 1'b0;
            default:                         op_illegal = 1'b1;
        endcase
    end

    // Requests and status are forced quiet while reset is held so an
    // in-flight access is visibly dropped, not just ignored internally.
    assign mem_req    = !reset && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we     = (state == S_MEM) && is_store;
    assign mem_addr   = (state == S_MEM) ? mar : pc;
    assign mem_wdata  = store_data;
    assign pc_out     = pc;
    assign ir_out     = ir;
    assign cc_out     = cc;
    assign halted     = !reset && (state == S_HALT);
    assign illegal_op = !reset && (state == S_EXEC) && op_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            cc         <= 3'b010;
            mar        <= '0;
            store_data <= '0;
            sr1_val    <= '0;
            sr2_val    <= '0;
            regs       <= '{default: '0};
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata[15:0];
                        pc    <= pc + WIDTH'(1);
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    sr1_val <= regs[sr1_sel];
                    sr2_val <= regs[sr2_sel];
                    state   <= S_EXEC;
                end

                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            regs[dr_sel] <= alu_result;
                            cc           <= cc_of(alu_result);
                        end
                        OP_BR: begin
                            if (branch_taken) begin
                                pc <= pc_rel;
                            end
                        end
                        OP_JMP: begin
                            pc <= sr1_val;
                        end
                        OP_LEA: begin
                            regs[dr_sel] <= pc_rel;
                        end
                        OP_LD, OP_ST: begin
                            mar        <= pc_rel;
                            store_data <= regs[dr_sel];
                            state      <= S_MEM;
                        end
                        OP_LDR, OP_STR: begin
                            mar        <= base_rel;
                            store_data <= regs[dr_sel];
                            state      <= S_MEM;
                        end
                        OP_TRAP: begin
                            state <= S_HALT;
                        end
                        default: begin
                            // unsupported opcode: pulse only, no state change
                        end
                    endcase
                end

                S_MEM: begin
                    if (mem_ready) begin
                        if (!is_store) begin
                            regs[dr_sel] <= mem_rdata;
                            cc           <= cc_of(mem_rdata);
                        end
                        state <= S_FETCH;
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_seq_datapath.sv
// tb_lc3_seq_datapath
// -------------------
// Directed bench for lc3_seq_datapath: a 16-bit instance runs small
// programs from a bench-side memory with configurable wait states, and a
// 32-bit instance covers the wide-datapath cases. Expected memory writes
// are queued when each program is loaded and compared as the cores issue
// them.
module tb_lc3_seq_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        rst16;
    logic        req16, we16, rdy16, halted16, ill16;
    logic [15:0] addr16, wdata16, rdata16, pc16, ir16;
    logic [2:0]  cc16;

    // 32-bit instance
    logic        rst32;
    logic        req32, we32, rdy32, halted32, ill32;
    logic [31:0] addr32, wdata32, rdata32, pc32;
    logic [15:0] ir32;
    logic [2:0]  cc32;

    lc3_seq_datapath u16 (
        .clk        (clk),
        .reset      (rst16),
        .mem_req    (req16),
        .mem_we     (we16),
        .mem_addr   (addr16),
        .mem_wdata  (wdata16),
        .mem_rdata  (rdata16),
        .mem_ready  (rdy16),
        .pc_out     (pc16),
        .ir_out     (ir16),
        .cc_out     (cc16),
        .halted     (halted16),
        .illegal_op (ill16)
    );

    lc3_seq_datapath #(.WIDTH(32)) u32 (
        .clk        (clk),
        .reset      (rst32),
        .mem_req    (req32),
        .mem_we     (we32),
        .mem_addr   (addr32),
        .mem_wdata  (wdata32),
        .mem_rdata  (rdata32),
        .mem_ready  (rdy32),
        .pc_out     (pc32),
        .ir_out     (ir32),
        .cc_out     (cc32),
        .halted     (halted32),
        .illegal_op (ill32)
    );

    // Bench memories, written only by the stimulus block
    logic [15:0] mem16 [0:65535];
    logic [31:0] mem32 [0:65535];

    int unsigned fetch_wait = 0;
    int unsigned data_wait  = 0;

    int unsigned cnt16  = 0;
    int unsigned cnt32  = 0;
    logic        pend16 = 1'b0;
    logic        pend32 = 1'b0;
    logic [32:0] hold16 = '0;
    logic [64:0] hold32 = '0;

    int stab_err  = 0;
    int halt_req  = 0;
    int ill_cnt16 = 0;
    int ill_cnt32 = 0;

    logic [63:0] wr_obs [$];
    logic [63:0] exp_q  [$];
    int          wr_idx;

    int checks;
    int failures;

    // Responders: a fetch is an access whose address equals the PC; all
    // others use the data wait count. Ready is driven high while no request
    // is pending so the core must ignore it, and junk data is returned.
    always_comb begin
        rdy16   = 1'b1;
        rdata16 = 16'hBEEF;
        if (req16) begin
            rdata16 = mem16[addr16];
            rdy16   = cnt16 >= ((we16 || (addr16 != pc16)) ? data_wait : fetch_wait);
        end
    end

    always_comb begin
        rdy32   = 1'b1;
        rdata32 = 32'hDEADBEEF;
        if (req32) begin
            rdata32 = mem32[addr32[15:0]];
            rdy32   = cnt32 >= ((we32 || (addr32 != pc32)) ? data_wait : fetch_wait);
        end
    end

    // Bus monitor: wait counters, request stability, write log, status
    always @(posedge clk) begin
        if (pend16 && req16 && ({addr16, we16, wdata16} != hold16)) stab_err++;
        if (pend32 && req32 && ({addr32, we32, wdata32} != hold32)) stab_err++;
        if (req16 && rdy16 && we16) wr_obs.push_back({16'h0, addr16, 16'h0, wdata16});
        if (req32 && rdy32 && we32) wr_obs.push_back({addr32, wdata32});
        if ((req16 && halted16) || (req32 && halted32)) halt_req++;
        if (ill16) ill_cnt16++;
        if (ill32) ill_cnt32++;
        pend16 <= req16 && !rdy16;
        pend32 <= req32 && !rdy32;
        hold16 <= {addr16, we16, wdata16};
        hold32 <= {addr32, we32, wdata32};
        cnt16  <= (req16 && !rdy16) ? cnt16 + 1 : 0;
        cnt32  <= (req32 && !rdy32) ? cnt32 + 1 : 0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare logged writes against the expected queue in order
    task automatic drain(input string tag);
        while ((exp_q.size() > 0) && (wr_idx < wr_obs.size())) begin
            check(tag, wr_obs[wr_idx], exp_q.pop_front());
            wr_idx++;
        end
        check({tag, "_missing"}, exp_q.size(), 0);
        check({tag, "_extra"}, wr_obs.size() - wr_idx, 0);
        wr_idx = wr_obs.size();
        exp_q.delete();
    endtask

    task automatic clear16();
        for (int a = 16'h3000; a < 16'h4100; a++) mem16[16'(a)] = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wr_idx   = 0;
        rst16    = 1'b1;
        rst32    = 1'b1;
        clear16();

        // ---- A: reset state, AND/ADD immediates, ST of the result
        mem16[16'h3000] = 16'h5260;  // AND R1,R1,#0
        mem16[16'h3001] = 16'h1265;  // ADD R1,R1,#5
        mem16[16'h3002] = 16'h1261;  // ADD R1,R1,#1
        mem16[16'h3003] = 16'h3210;  // ST  R1,#0x10 -> 0x3014
        exp_q.push_back({32'h3014, 32'h0006});
        cyc(2);
        check("rst_req", req16, 0);
        check("rst_halted", halted16, 0);
        check("rst_illegal", ill16, 0);
        check("rst_pc", pc16, 16'h3000);
        check("rst_ir", ir16, 0);
        check("rst_cc", cc16, 3'b010);
        rst16 = 1'b0;
        #1;
        check("first_fetch_req", req16, 1);
        check("first_fetch_addr", {we16, addr16}, {1'b0, 16'h3000});
        cyc(3);
        check("and0_pc", pc16, 16'h3001);
        check("and0_cc", cc16, 3'b010);
        cyc(3);
        check("add5_cc", {pc16, cc16}, {16'h3002, 3'b001});
        cyc(3);
        check("add1_pc", pc16, 16'h3003);
        check("add1_ir", ir16, 16'h1261);
        check("add1_cc", cc16, 3'b001);
        cyc(3);
        check("st_req", {req16, we16}, 2'b11);
        check("st_addr", addr16, 16'h3014);
        check("st_wdata", wdata16, 16'h0006);
        cyc(1);
        check("st_pc", pc16, 16'h3004);
        drain("wr_a");

        // ---- B: branches taken / not taken / never, negative offset
        rst16 = 1'b1;
        cyc(1);
        clear16();
        mem16[16'h3000] = 16'h0405;  // BRz +5 (CC=Z after reset)
        mem16[16'h3006] = 16'h1261;  // ADD R1,R1,#1 -> P
        mem16[16'h3007] = 16'h0405;  // BRz +5, not taken
        mem16[16'h3008] = 16'h0005;  // nzp=000, never taken
        mem16[16'h3009] = 16'h03FE;  // BRp -2 -> 0x3008
        rst16 = 1'b0;
        #1;
        cyc(3);
        check("brz_taken_pc", pc16, 16'h3006);
        cyc(3);
        check("add_p_cc", cc16, 3'b001);
        cyc(3);
        check("brz_not_taken_pc", pc16, 16'h3008);
        cyc(3);
        check("br_nzp0_pc", pc16, 16'h3009);
        cyc(3);
        check("brp_back_pc", pc16, 16'h3008);

        // ---- C: LD with data wait states, then ST of the loaded value
        rst16 = 1'b1;
        cyc(1);
        clear16();
        mem16[16'h3000] = 16'h2202;  // LD R1,#2 -> 0x3003
        mem16[16'h3001] = 16'h3220;  // ST R1,#0x20 -> 0x3022
        mem16[16'h3003] = 16'h8000;
        exp_q.push_back({32'h3022, 32'h8000});
        fetch_wait = 0;
        data_wait  = 3;
        rst16 = 1'b0;
        #1;
        cyc(3);
        for (int i = 0; i < 4; i++) begin
            check("ld_wait_bus", {req16, we16, addr16}, {2'b10, 16'h3003});
            cyc(1);
        end
        check("ld_cc", cc16, 3'b100);
        check("ld_next_fetch", {req16, addr16}, {1'b1, 16'h3001});
        cyc(8);
        drain("wr_c");
        check("stable_c", stab_err, 0);

        // ---- E: reset in the middle of a data access and of a fetch
        rst16 = 1'b1;
        cyc(1);
        clear16();
        mem16[16'h3000] = 16'h2202;
        mem16[16'h3003] = 16'h1111;
        fetch_wait = 0;
        data_wait  = 5;
        rst16 = 1'b0;
        #1;
        cyc(3);
        check("mid_mem_req", {req16, addr16}, {1'b1, 16'h3003});
        rst16 = 1'b1;
        #1;
        check("mid_mem_req_drop", req16, 0);
        cyc(1);
        check("abort_mem_state", {pc16, ir16, cc16}, {16'h3000, 16'h0000, 3'b010});
        fetch_wait = 3;
        rst16 = 1'b0;
        cyc(2);
        rst16 = 1'b1;
        cyc(1);
        check("abort_fetch_state", {pc16, ir16}, {16'h3000, 16'h0000});
        drain("wr_e");

        // ---- D: LD/STR/NOT/LEA/AND/JMP/illegal/TRAP program with waits
        clear16();
        mem16[16'h3000] = 16'h2420;  // LD  R2,#0x20 -> 0x3021
        mem16[16'h3001] = 16'h2620;  // LD  R3,#0x20 -> 0x3022
        mem16[16'h3002] = 16'h74FF;  // STR R2,R3,#-1
        mem16[16'h3003] = 16'h98BF;  // NOT R4,R2
        mem16[16'h3004] = 16'h3810;  // ST  R4,#0x10 -> 0x3015
        mem16[16'h3005] = 16'hEBFB;  // LEA R5,#-5 -> 0x3001
        mem16[16'h3006] = 16'h7AC0;  // STR R5,R3,#0
        mem16[16'h3007] = 16'h5C83;  // AND R6,R2,R3 -> 0
        mem16[16'h3008] = 16'h3C10;  // ST  R6,#0x10 -> 0x3019
        mem16[16'h3009] = 16'h1E83;  // ADD R7,R2,R3 -> 0x5234
        mem16[16'h300A] = 16'hE005;  // LEA R0,#5 -> 0x3010
        mem16[16'h300B] = 16'hC000;  // JMP R0
        mem16[16'h300C] = 16'hF025;  // skipped by the jump
        mem16[16'h3010] = 16'h3E20;  // ST  R7,#0x20 -> 0x3031
        mem16[16'h3011] = 16'hD000;  // unsupported opcode
        mem16[16'h3012] = 16'h3E20;  // ST  R7,#0x20 -> 0x3033
        mem16[16'h3013] = 16'hF025;  // TRAP
        mem16[16'h3021] = 16'h1234;
        mem16[16'h3022] = 16'h4000;
        exp_q.push_back({32'h3FFF, 32'h1234});
        exp_q.push_back({32'h3015, 32'hEDCB});
        exp_q.push_back({32'h4000, 32'h3001});
        exp_q.push_back({32'h3019, 32'h0000});
        exp_q.push_back({32'h3031, 32'h5234});
        exp_q.push_back({32'h3033, 32'h5234});
        fetch_wait = 1;
        data_wait  = 2;
        rst16 = 1'b0;
        #1;
        for (int i = 0; (i < 1000) && !halted16; i++) @(negedge clk);
        check("halt_reached", halted16, 1);
        drain("wr_d");
        check("halt_pc", pc16, 16'h3014);
        check("halt_ir", ir16, 16'hF025);
        check("halt_cc", cc16, 3'b001);
        check("illegal_pulses_16", ill_cnt16, 1);
        cyc(20);
        check("halt_hold", {halted16, req16, pc16}, {2'b10, 16'h3014});
        check("halt_no_req", halt_req, 0);
        check("stable_d", stab_err, 0);
        rst16 = 1'b1;
        #1;
        check("halt_reset_out", {halted16, req16}, 2'b00);
        cyc(1);
        check("halt_reset_pc", pc16, 16'h3000);
        fetch_wait = 0;
        data_wait  = 0;
        rst16 = 1'b0;
        #1;
        check("resume_fetch", {req16, we16, addr16}, {2'b10, 16'h3000});
        rst16 = 1'b1;
        cyc(1);

        // ---- F: 32-bit datapath, wrap to all-ones, unsupported opcode
        mem32[16'h3000] = 32'h0000127F;  // ADD R1,R1,#-1
        mem32[16'h3001] = 32'h0000D000;  // unsupported opcode
        mem32[16'h3002] = 32'h00003210;  // ST R1,#0x10 -> 0x3013
        mem32[16'h3003] = 32'h0000F025;  // TRAP
        exp_q.push_back({32'h3013, 32'hFFFFFFFF});
        cyc(1);
        check("w32_rst_pc", {req32, pc32}, {1'b0, 32'h3000});
        rst32 = 1'b0;
        #1;
        check("w32_first_fetch", {req32, addr32}, {1'b1, 32'h3000});
        cyc(3);
        check("w32_add_cc", {pc32, cc32}, {32'h3001, 3'b100});
        cyc(2);
        check("w32_illegal_high", ill32, 1);
        cyc(1);
        check("w32_illegal_low", ill32, 0);
        check("w32_illegal_nochange", {pc32, cc32}, {32'h3002, 3'b100});
        cyc(3);
        check("w32_st_bus", {req32, we32, addr32}, {2'b11, 32'h3013});
        check("w32_st_wdata", wdata32, 32'hFFFFFFFF);
        cyc(1);
        drain("wr_f");
        cyc(3);
        check("w32_halted", {halted32, req32, ir32}, {2'b10, 16'hF025});
        check("illegal_pulses_32", ill_cnt32, 1);
        cyc(5);
        check("w32_halt_no_req", halt_req, 0);
        check("stable_f", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
